// File: rtl/pu_or1k_pkg.sv
// Shared types and defaults for the OR1K cappuccino pipeline control slice.
// Holds the controller state encoding and the default drain depth.
package pu_or1k_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_REFILL,
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN,
        ST_HALT
    } pipe_state_e;

    localparam int DRAIN_DEPTH_DEFAULT = 3;

    // Wide enough for the largest legal drain depth (7).
    localparam int DRAIN_CNT_W = 3;

endpackage

// File: rtl/pu_or1k_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// A synchronous clear has priority over the increment.
module pu_or1k_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pu_or1k_pipeline_ctrl_cappuccino.sv
// Pipeline advance/flush controller: refills after flushes, drains the
// pipeline behind fetch for a debug halt, and counts RUN stall cycles.
module pu_or1k_pipeline_ctrl_cappuccino
    import pu_or1k_pkg::*;
#(
    parameter string FEATURE_DEBUGUNIT     = "NONE",
    parameter int    OPTION_DRAIN_DEPTH    = DRAIN_DEPTH_DEFAULT,
    parameter int    OPTION_STALLCNT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fetch_valid_i,
    input  logic                             decode_valid_i,
    input  logic                             execute_valid_i,
    input  logic                             ctrl_valid_i,
    input  logic                             exception_i,
    input  logic                             op_rfe_i,
    input  logic                             du_stall_i,
    input  logic                             du_restart_i,
    output logic                             padv_fetch_o,
    output logic                             padv_decode_o,
    output logic                             padv_execute_o,
    output logic                             padv_ctrl_o,
    output logic                             pipeline_flush_o,
    output logic                             execute_bubble_o,
    output logic                             doing_rfe_o,
    output logic                             du_stalled_o,
    output logic [OPTION_STALLCNT_WIDTH-1:0] stall_cycles_o
);

    localparam logic                   DU_EN      = (FEATURE_DEBUGUNIT == "ENABLED");
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(OPTION_DRAIN_DEPTH);

    pipe_state_e            state_q, state_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d, drain_cnt_dec;
    logic                   du_pending_q, du_pending_d;
    logic                   doing_rfe_q, doing_rfe_d;
    logic                   execute_bubble_q, execute_bubble_d;

    logic chain_ctrl, chain_execute, chain_decode, chain_fetch;
    logic flush_req, stall_inc;

    // A stage advances only if every stage ahead of it advances too.
    assign chain_ctrl    = ctrl_valid_i;
    assign chain_execute = chain_ctrl & execute_valid_i;
    assign chain_decode  = chain_execute & decode_valid_i;
    assign chain_fetch   = chain_decode & fetch_valid_i;

    assign flush_req     = ctrl_valid_i & (exception_i | op_rfe_i);
    assign drain_cnt_dec = drain_cnt_q - DRAIN_CNT_W'(chain_ctrl);

    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that left one unassigned would infer a latch.
        state_d          = state_q;
        drain_cnt_d      = drain_cnt_q;
        doing_rfe_d      = doing_rfe_q;
        du_pending_d     = du_pending_q | (DU_EN & du_stall_i);
        padv_fetch_o     = 1'b0;
        padv_decode_o    = 1'b0;
        padv_execute_o   = 1'b0;
        padv_ctrl_o      = 1'b0;
        pipeline_flush_o = 1'b0;
        du_stalled_o     = 1'b0;

        unique case (state_q)
            ST_RESET: begin
                state_d = ST_REFILL;
            end
            ST_REFILL: begin
                padv_fetch_o = 1'b1;
                if (fetch_valid_i) begin
                    doing_rfe_d = 1'b0;
                    if (du_pending_q) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                padv_ctrl_o    = chain_ctrl;
                padv_execute_o = chain_execute;
                padv_decode_o  = chain_decode;
                padv_fetch_o   = chain_fetch;
                if (flush_req) begin
                    state_d     = ST_FLUSH;
                    doing_rfe_d = op_rfe_i & ~exception_i;
                end else if (du_pending_q) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                padv_ctrl_o    = chain_ctrl;
                padv_execute_o = chain_execute;
                padv_decode_o  = chain_decode;
                if (flush_req) begin
                    // Debug request stays pending; the drain restarts after refill.
                    state_d     = ST_FLUSH;
                    doing_rfe_d = op_rfe_i & ~exception_i;
                end else begin
                    drain_cnt_d = drain_cnt_dec;
                    if (drain_cnt_dec == '0) begin
                        state_d      = ST_HALT;
                        du_pending_d = 1'b0;
                    end
                end
            end
            ST_FLUSH: begin
                pipeline_flush_o = 1'b1;
                state_d          = ST_REFILL;
            end
            ST_HALT: begin
                du_stalled_o = 1'b1;
                if (du_restart_i) begin
                    state_d     = ST_FLUSH;
                    doing_rfe_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    always_comb begin
        execute_bubble_d = execute_bubble_q;
        if (pipeline_flush_o) begin
            execute_bubble_d = 1'b1;
        end else if (padv_execute_o) begin
            execute_bubble_d = ~padv_decode_o;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_RESET;
            drain_cnt_q      <= '0;
            du_pending_q     <= 1'b0;
            doing_rfe_q      <= 1'b0;
            execute_bubble_q <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q          <= state_d;
            drain_cnt_q      <= drain_cnt_d;
            du_pending_q     <= du_pending_d;
            doing_rfe_q      <= doing_rfe_d;
            execute_bubble_q <= execute_bubble_d;
        end
    end

    assign stall_inc = (state_q == ST_RUN) & ~padv_ctrl_o;

    pu_or1k_sat_counter #(
        .WIDTH (OPTION_STALLCNT_WIDTH)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (stall_inc),
        .clear   (1'b0),
        .count_o (stall_cycles_o)
    );

    assign doing_rfe_o      = doing_rfe_q;
    assign execute_bubble_o = execute_bubble_q;

endmodule

// File: tb/tb_pu_or1k_pipeline_ctrl_cappuccino.sv
// Bench for the pipeline controller: vector table, hand-written debug and
// flush sequences, randomized run against a phase-level model, saturation.
module tb_pu_or1k_pipeline_ctrl_cappuccino;

    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_valid_i = 1'b0, decode_valid_i = 1'b0;
    logic        execute_valid_i = 1'b0, ctrl_valid_i = 1'b0;
    logic        exception_i = 1'b0, op_rfe_i = 1'b0;
    logic        du_stall_i = 1'b0, du_restart_i = 1'b0;
    logic        padv_fetch_o, padv_decode_o, padv_execute_o, padv_ctrl_o;
    logic        pipeline_flush_o, execute_bubble_o, doing_rfe_o, du_stalled_o;
    logic [15:0] stall_cycles_o;

    int n_pass  = 0;
    int n_total = 0;

    pu_or1k_pipeline_ctrl_cappuccino #(
        .FEATURE_DEBUGUNIT     ("ENABLED"),
        .OPTION_DRAIN_DEPTH    (DEPTH),
        .OPTION_STALLCNT_WIDTH (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_valid_i    (fetch_valid_i),
        .decode_valid_i   (decode_valid_i),
        .execute_valid_i  (execute_valid_i),
        .ctrl_valid_i     (ctrl_valid_i),
        .exception_i      (exception_i),
        .op_rfe_i         (op_rfe_i),
        .du_stall_i       (du_stall_i),
        .du_restart_i     (du_restart_i),
        .padv_fetch_o     (padv_fetch_o),
        .padv_decode_o    (padv_decode_o),
        .padv_execute_o   (padv_execute_o),
        .padv_ctrl_o      (padv_ctrl_o),
        .pipeline_flush_o (pipeline_flush_o),
        .execute_bubble_o (execute_bubble_o),
        .doing_rfe_o      (doing_rfe_o),
        .du_stalled_o     (du_stalled_o),
        .stall_cycles_o   (stall_cycles_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic        pf, pd, pe, pc;
        logic        flush, bubble, rfe, stalled;
        logic [15:0] stall;
    } outs_t;

    // Reference model: what the controller is doing, in words.
    typedef enum int {P_RESET, P_REFILL, P_RUN, P_FLUSH, P_DRAIN, P_HALT} phase_e;

    phase_e m_phase;
    bit     m_pending, m_rfe, m_bubble;
    int     m_left, m_stall;

    function automatic void model_reset();
        m_phase = P_RESET; m_pending = 0; m_rfe = 0; m_bubble = 1;
        m_left = 0; m_stall = 0;
    endfunction

    function automatic outs_t model_outs();
        outs_t o;
        bit go_c, go_e, go_d, go_f;
        o = '0;
        go_c = ctrl_valid_i;
        go_e = go_c && execute_valid_i;
        go_d = go_e && decode_valid_i;
        go_f = go_d && fetch_valid_i;
        case (m_phase)
            P_RUN:    begin o.pc = go_c; o.pe = go_e; o.pd = go_d; o.pf = go_f; end
            P_DRAIN:  begin o.pc = go_c; o.pe = go_e; o.pd = go_d; end
            P_REFILL: o.pf = 1'b1;
            P_FLUSH:  o.flush = 1'b1;
            P_HALT:   o.stalled = 1'b1;
            default:  ;
        endcase
        o.rfe    = m_rfe;
        o.bubble = m_bubble;
        o.stall  = 16'(m_stall);
        return o;
    endfunction

    task automatic model_step();
        outs_t o;
        bit    flush_req, to_halt;
        if (!rst) begin
            model_reset();
            return;
        end
        o = model_outs();
        flush_req = ctrl_valid_i && (exception_i || op_rfe_i);
        to_halt = 0;
        if (o.flush) m_bubble = 1;
        else if (o.pe) m_bubble = !o.pd;
        if (m_phase == P_RUN && !o.pc && m_stall < 65535) m_stall++;
        case (m_phase)
            P_RESET: m_phase = P_REFILL;
            P_REFILL: if (fetch_valid_i) begin
                m_rfe = 0;
                if (m_pending) begin m_phase = P_DRAIN; m_left = DEPTH; end
                else m_phase = P_RUN;
            end
            P_RUN, P_DRAIN: begin
                if (flush_req) begin
                    m_phase = P_FLUSH;
                    m_rfe = op_rfe_i && !exception_i;
                end else if (m_phase == P_RUN) begin
                    if (m_pending) begin m_phase = P_DRAIN; m_left = DEPTH; end
                end else if (o.pc) begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_HALT; to_halt = 1; end
                end
            end
            P_FLUSH: m_phase = P_REFILL;
            P_HALT: if (du_restart_i) begin m_phase = P_FLUSH; m_rfe = 0; end
            default: ;
        endcase
        if (to_halt) m_pending = 0;
        else if (du_stall_i) m_pending = 1;
    endtask

    function automatic outs_t dut_outs();
        outs_t o;
        o.pf = padv_fetch_o; o.pd = padv_decode_o; o.pe = padv_execute_o; o.pc = padv_ctrl_o;
        o.flush = pipeline_flush_o; o.bubble = execute_bubble_o;
        o.rfe = doing_rfe_o; o.stalled = du_stalled_o; o.stall = stall_cycles_o;
        return o;
    endfunction

    function automatic logic [3:0] padv4();
        return {padv_fetch_o, padv_decode_o, padv_execute_o, padv_ctrl_o};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic look();
        #3;
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_valids(input logic [3:0] v);
        {fetch_valid_i, decode_valid_i, execute_valid_i, ctrl_valid_i} = v;
    endtask

    task automatic to_run();
        bit reached;
        reached = 0;
        set_valids(4'hF);
        exception_i = 0; op_rfe_i = 0; du_stall_i = 0; du_restart_i = 0;
        for (int i = 0; i < 10 && !reached; i++) begin
            look();
            reached = (padv4() == 4'hF);
            adv();
        end
        check("reach_run", 32'(reached), 32'd1);
    endtask

    task automatic drain_until_halt(input bit toggle, output int pulses, output bit fetch_seen);
        int cnt;
        bit done;
        cnt = 0; done = 0; fetch_seen = 0;
        for (int i = 0; i < 30; i++) begin
            ctrl_valid_i = toggle ? logic'(i % 2 == 0) : 1'b1;
            look();
            if (du_stalled_o) begin
                done = 1;
                break;
            end
            cnt += int'(padv_ctrl_o);
            fetch_seen |= padv_fetch_o;
            adv();
        end
        pulses = done ? cnt : -1;
    endtask

    task automatic restart_to_run();
        du_restart_i = 1;
        look();
        adv();
        du_restart_i = 0;
        to_run();
    endtask

    typedef struct {
        logic [3:0] valids;
        logic [3:0] exp_padv;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int  pulses;
        bit  fseen;

        vecs[0] = '{4'b1111, 4'b1111};
        vecs[1] = '{4'b0111, 4'b0111};
        vecs[2] = '{4'b1011, 4'b0011};
        vecs[3] = '{4'b1101, 4'b0001};
        vecs[4] = '{4'b1110, 4'b0000};
        vecs[5] = '{4'b0001, 4'b0001};
        vecs[6] = '{4'b0011, 4'b0011};
        vecs[7] = '{4'b1100, 4'b0000};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1;

        // Reset release and refill timing.
        look();
        check("reset_outputs", 32'(dut_outs()), 32'h040000);
        adv();
        look();
        check("refill_cycle2", 32'(dut_outs()), 32'h840000);
        adv();
        set_valids(4'hF);
        look();
        check("refill_cycle3", 32'(dut_outs()), 32'h840000);
        adv();
        look();
        check("run_cycle4", 32'(dut_outs()), 32'hF40000);
        adv();

        // RUN advance chain.
        for (int i = 0; i < 8; i++) begin
            set_valids(vecs[i].valids);
            look();
            check($sformatf("chain_vec%0d", i), 32'(padv4()), 32'(vecs[i].exp_padv));
            adv();
        end

        // Exception and rfe together: exception wins.
        set_valids(4'hF); exception_i = 1; op_rfe_i = 1;
        look();
        check("exc_rfe_cycle_padv", 32'(padv4()), 32'hF);
        adv();
        exception_i = 0; op_rfe_i = 0;
        look();
        check("flush_after_exc", 32'({pipeline_flush_o, padv4(), doing_rfe_o}), 32'b1_0000_0);
        adv();
        look();
        check("refill_after_flush", 32'({pipeline_flush_o, padv4(), execute_bubble_o}), 32'b0_1000_1);
        adv();
        look();
        check("run_after_refill", 32'(padv4()), 32'hF);
        adv();

        // rfe alone: doing_rfe holds through refill, clears on leaving it.
        op_rfe_i = 1;
        look();
        adv();
        op_rfe_i = 0;
        look();
        check("rfe_flush", 32'({pipeline_flush_o, doing_rfe_o}), 32'b11);
        adv();
        fetch_valid_i = 0;
        look();
        check("rfe_refill_wait", 32'({padv4(), doing_rfe_o}), 32'b1000_1);
        adv();
        fetch_valid_i = 1;
        look();
        check("rfe_refill_leave", 32'(doing_rfe_o), 32'd1);
        adv();
        look();
        check("rfe_cleared_in_run", 32'({padv4(), doing_rfe_o}), 32'b1111_0);
        adv();

        // Exception without ctrl_valid does not flush.
        ctrl_valid_i = 0; exception_i = 1;
        look();
        adv();
        ctrl_valid_i = 1; exception_i = 0;
        look();
        check("exc_needs_ctrl_valid", 32'({pipeline_flush_o, padv4()}), 32'b0_1111);
        adv();

        // Debug stall with ctrl_valid toggling: three ctrl pulses then HALT.
        du_stall_i = 1;
        look();
        adv();
        du_stall_i = 0; ctrl_valid_i = 0;
        look();
        adv();
        drain_until_halt(1, pulses, fseen);
        check("drain_toggle_pulses", 32'(pulses), 32'd3);
        check("drain_no_fetch", 32'(fseen), 32'd0);
        check("halt_outputs", 32'({du_stalled_o, padv4(), pipeline_flush_o}), 32'b1_0000_0);
        adv();

        // Restart and stall together in HALT: restart wins, stall re-arms.
        set_valids(4'hF); du_restart_i = 1; du_stall_i = 1;
        look();
        check("halt_before_restart", 32'(du_stalled_o), 32'd1);
        adv();
        du_restart_i = 0; du_stall_i = 0;
        look();
        check("restart_flush", 32'({pipeline_flush_o, doing_rfe_o, du_stalled_o, padv4()}), 32'b1_0_0_0000);
        adv();
        look();
        check("restart_refill", 32'(padv4()), 32'b1000);
        adv();
        drain_until_halt(0, pulses, fseen);
        check("redrain_pulses", 32'(pulses), 32'd3);
        adv();
        restart_to_run();

        // Exception mid-drain: flush, refill, drain reloaded to full depth.
        du_stall_i = 1;
        look();
        adv();
        du_stall_i = 0;
        look();
        adv();
        look();
        check("drain_first", 32'(padv4()), 32'b0111);
        adv();
        exception_i = 1;
        look();
        adv();
        exception_i = 0;
        look();
        check("drain_exc_flush", 32'({pipeline_flush_o, padv4()}), 32'b1_0000);
        adv();
        look();
        check("drain_exc_refill", 32'(padv4()), 32'b1000);
        adv();
        drain_until_halt(0, pulses, fseen);
        check("drain_reload_pulses", 32'(pulses), 32'd3);
        adv();
        restart_to_run();

        // Asynchronous reset mid-drain clears every pending thing.
        du_stall_i = 1;
        look();
        adv();
        du_stall_i = 0;
        look();
        adv();
        look();
        adv();
        rst = 0;
        #1;
        model_reset();
        check("async_reset_in_drain", 32'(dut_outs()), 32'h040000);
        adv();
        rst = 1;
        look();
        check("reset_state_after_abort", 32'(dut_outs()), 32'h040000);
        adv();
        adv();
        for (int i = 0; i < 3; i++) begin
            look();
            check($sformatf("no_drain_after_reset%0d", i), 32'(padv4()), 32'hF);
            adv();
        end

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) begin
            fetch_valid_i   = ($urandom_range(3) != 0);
            decode_valid_i  = ($urandom_range(3) != 0);
            execute_valid_i = ($urandom_range(3) != 0);
            ctrl_valid_i    = ($urandom_range(3) != 0);
            exception_i     = ($urandom_range(15) == 0);
            op_rfe_i        = ($urandom_range(15) == 0);
            du_stall_i      = ($urandom_range(39) == 0);
            du_restart_i    = (m_phase == P_HALT) ? ($urandom_range(2) == 0) : ($urandom_range(31) == 0);
            look();
            check("rand_cycle", 32'(dut_outs()), 32'(model_outs()));
            adv();
        end

        // Stall counter saturation.
        exception_i = 0; op_rfe_i = 0; du_stall_i = 0; du_restart_i = 0;
        rst = 0;
        #1;
        model_reset();
        adv();
        rst = 1;
        set_valids(4'b1110);
        adv();
        adv();
        look();
        check("stall_start", 32'(stall_cycles_o), 32'd0);
        for (int k = 1; k <= 70000; k++) begin
            adv();
            if (k == 100) begin
                look();
                check("stall_count_100", 32'(stall_cycles_o), 32'd100);
            end
            if (k == 65534) begin
                look();
                check("stall_count_fffe", 32'(stall_cycles_o), 32'hFFFE);
            end
            if (k == 65535) begin
                look();
                check("stall_count_ffff", 32'(stall_cycles_o), 32'hFFFF);
            end
        end
        look();
        check("stall_saturated", 32'(stall_cycles_o), 32'hFFFF);
        repeat (10) adv();
        look();
        check("stall_stays_saturated", 32'(stall_cycles_o), 32'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
